// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: word geometry, the canonical NOP and the
// IF/ID bundle type produced by the fetch stage.
package mips_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // sll $0,$0,0
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              valid;
    } if_bundle_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from downstream, instruction memory address/data,
// the IF/ID output and the optional performance counters.
// master = fetch unit side, slave = pipeline/memory side.
interface fetch_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) ();

    logic                 stall;
    logic                 redirect;
    logic [WORD_W-1:0]    redirect_target;
    logic [WORD_W-1:0]    imem_addr;
    logic [WORD_W-1:0]    imem_instruction;
    logic [WORD_W-1:0]    if_pc;
    logic [WORD_W-1:0]    if_instr;
    logic                 if_valid;
    logic [CNT_WIDTH-1:0] perf_fetched;
    logic [CNT_WIDTH-1:0] perf_stalls;

    modport master (
        input  stall, redirect, redirect_target, imem_instruction,
        output imem_addr, if_pc, if_instr, if_valid, perf_fetched, perf_stalls
    );

    modport slave (
        output stall, redirect, redirect_target, imem_instruction,
        input  imem_addr, if_pc, if_instr, if_valid, perf_fetched, perf_stalls
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// Saturating, enable-driven event counter used by the fetch unit's
// performance monitors. Only built when FETCH_PERF_CNT_EN is defined, so the
// default build contains no counter logic at all.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Count enabled cycles, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Program counter and fetch control in front of a 1-cycle synchronous
// instruction memory. Pairs each returned word with its PC, handles stall
// (re-read the held word) and redirect (kill current output, fetch target
// the same cycle, so no bubble).
// Optional: FETCH_PERF_CNT_EN builds the fetched/stall performance counters.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned       CNT_WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] fpc_q, fpc_d;
    logic              vq_q, vq_d;
    logic [WORD_W-1:0] sel_addr;
    if_bundle_t        if_out;

    // Address select: redirect beats stall beats sequential.
    always_comb begin
        sel_addr = pc_q;
        if (bus.redirect) begin
            sel_addr = bus.redirect_target & ~WORD_W'(INSTR_BYTES - 1);
        end else if (bus.stall) begin
            // Re-present the in-flight address so the memory output stays put.
            sel_addr = fpc_q;
        end
    end

    assign bus.imem_addr = sel_addr >> 2;

    // Next state: any non-stalled cycle (or a redirect) advances to sel_addr.
    always_comb begin
        pc_d  = pc_q;
        fpc_d = fpc_q;
        vq_d  = vq_q;
        if (bus.redirect || !bus.stall) begin
            fpc_d = sel_addr;
            pc_d  = sel_addr + WORD_W'(INSTR_BYTES);
            vq_d  = 1'b1;
        end
    end

    // PC / in-flight PC / valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            fpc_q <= RESET_PC;
            vq_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            fpc_q <= fpc_d;
            vq_q  <= vq_d;
        end
    end

    // IF/ID output: a redirect squashes whatever is on the output this cycle.
    always_comb begin
        if_out.pc    = fpc_q;
        if_out.valid = vq_q & ~bus.redirect;
        if_out.instr = if_out.valid ? bus.imem_instruction : NOP;
    end

    assign bus.if_pc    = if_out.pc;
    assign bus.if_instr = if_out.instr;
    assign bus.if_valid = if_out.valid;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter #(
        .Width (CNT_WIDTH)
    ) u_cnt_fetched (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (if_out.valid & ~bus.stall),
        .cnt_o (bus.perf_fetched)
    );

    fetch_perf_counter #(
        .Width (CNT_WIDTH)
    ) u_cnt_stalls (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (bus.stall & ~bus.redirect),
        .cnt_o (bus.perf_stalls)
    );
`else
    assign bus.perf_fetched = {CNT_WIDTH{1'b0}};
    assign bus.perf_stalls  = {CNT_WIDTH{1'b0}};
`endif

endmodule
